// File: rtl/vram_arbiter_if.sv
// ----------------------------------------------------------------------------
// vram_arbiter_if: requester and frame-buffer RAM pins of vram_arbiter. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface vram_arbiter_if #(
   parameter int unsigned ADDR_W = 15,
   parameter int unsigned DATA_W = 8
);
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic              disp_gnt;
   logic              disp_rvalid;

   logic              draw_req;
   logic              draw_we;
   logic [ADDR_W-1:0] draw_addr;
   logic [DATA_W-1:0] draw_wdata;
   logic              draw_gnt;
   logic              draw_rvalid;

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_rvalid;

   logic [DATA_W-1:0] rd_data;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  disp_req, disp_addr,
      input  draw_req, draw_we, draw_addr, draw_wdata,
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  mem_rdata,
      output disp_gnt, disp_rvalid, draw_gnt, draw_rvalid, cpu_gnt, cpu_rvalid,
      output rd_data, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output disp_req, disp_addr,
      output draw_req, draw_we, draw_addr, draw_wdata,
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output mem_rdata,
      input  disp_gnt, disp_rvalid, draw_gnt, draw_rvalid, cpu_gnt, cpu_rvalid,
      input  rd_data, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

`default_nettype wire

// File: rtl/vram_arbiter.sv
// ----------------------------------------------------------------------------
// vram_arbiter: display-priority, starvation-limited RAM arbiter with
// round-robin draw/CPU sharing and tagged 2-cycle read return. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vram_arbiter #(
   parameter int unsigned ADDR_W     = 15,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned STARVE_MAX = 7
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   vram_arbiter_if.slave bus
);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   typedef enum logic {RR_DRAW = 1'b0, RR_CPU = 1'b1} rr_t;
   typedef enum logic [1:0] {SEL_NONE = 2'd0, SEL_DISP = 2'd1,
                             SEL_DRAW = 2'd2, SEL_CPU  = 2'd3} sel_t;

   rr_t               rr_last;
   rr_t               rr_next;
   logic [3:0]        starve_cnt;
   logic [3:0]        starve_next;
   sel_t              sel;
   logic              lower_req;
   logic              starve_block;
   logic              iss_we;
   logic [ADDR_W-1:0] iss_addr;
   logic [DATA_W-1:0] iss_wdata;
   logic [2:0]        iss_rd;
   logic [2:0]        rd_tag_iss;
   logic [2:0]        rd_tag_ret;

   always_comb begin
      lower_req    = bus.draw_req | bus.cpu_req;
      starve_block = (STARVE_MAX != 0) && (starve_cnt == STARVE_LIM) && lower_req;
      sel          = SEL_NONE;
      if (bus.disp_req && !starve_block) begin
         sel = SEL_DISP;
      end else if (bus.draw_req && bus.cpu_req) begin
         sel = (rr_last == RR_CPU) ? SEL_DRAW : SEL_CPU;
      end else if (bus.draw_req) begin
         sel = SEL_DRAW;
      end else if (bus.cpu_req) begin
         sel = SEL_CPU;
      end
   end

   assign bus.disp_gnt = (sel == SEL_DISP);
   assign bus.draw_gnt = (sel == SEL_DRAW);
   assign bus.cpu_gnt  = (sel == SEL_CPU);

   always_comb begin
      starve_next = starve_cnt;
      rr_next     = rr_last;
      if (sel == SEL_DRAW || sel == SEL_CPU || !lower_req) begin
         starve_next = '0;
      end else if (sel == SEL_DISP && starve_cnt != STARVE_LIM) begin
         starve_next = starve_cnt + 4'd1;
      end
      if (sel == SEL_DRAW) begin
         rr_next = RR_DRAW;
      end else if (sel == SEL_CPU) begin
         rr_next = RR_CPU;
      end
   end

   // Issue mux; iss_rd is the one-hot {cpu, draw, disp} tag of a read issue.
   always_comb begin
      iss_we    = 1'b0;
      iss_addr  = bus.disp_addr;
      iss_wdata = bus.draw_wdata;
      iss_rd    = 3'b000;
      case (sel)
         SEL_DISP: begin
            iss_addr = bus.disp_addr;
            iss_rd   = 3'b001;
         end
         SEL_DRAW: begin
            iss_we    = bus.draw_we;
            iss_addr  = bus.draw_addr;
            iss_wdata = bus.draw_wdata;
            iss_rd    = {1'b0, ~bus.draw_we, 1'b0};
         end
         SEL_CPU: begin
            iss_we    = bus.cpu_we;
            iss_addr  = bus.cpu_addr;
            iss_wdata = bus.cpu_wdata;
            iss_rd    = {~bus.cpu_we, 2'b00};
         end
         default: begin
            iss_we = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt    <= '0;
         rr_last       <= RR_CPU;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         rd_tag_iss    <= '0;
         rd_tag_ret    <= '0;
      end else begin
         starve_cnt <= starve_next;
         rr_last    <= rr_next;
         bus.mem_en <= (sel != SEL_NONE);
         bus.mem_we <= iss_we;
         if (sel != SEL_NONE) begin
            bus.mem_addr  <= iss_addr;
            bus.mem_wdata <= iss_wdata;
         end
         rd_tag_iss <= iss_rd;
         rd_tag_ret <= rd_tag_iss;
      end
   end

   assign bus.disp_rvalid = rd_tag_ret[0];
   assign bus.draw_rvalid = rd_tag_ret[1];
   assign bus.cpu_rvalid  = rd_tag_ret[2];
   assign bus.rd_data     = bus.mem_rdata;

endmodule

`default_nettype wire
